dma_frame_scheduler: RTL and testbench
======================================

# dma_frame_scheduler

Frame-level read-address sequencer for the DMA read path. It accepts one frame descriptor (base address, line stride, line length, line count) and walks the frame line by line. For each line it pulses an external in-line offset former and turns each of that former's (offset, burst length) outputs into an AXI AR command at line_base + offset. It sits between the DMA register file and the AXI read-address channel.

## Interface
Parameters:
- ADDR_W, 32: address width, also the width of stride and line length.
- DATA_W, 64: bus width in bits, power of 2; used only for the stride alignment check.
- LINES_W, 16: width of the line counter.

Ports:
- clk_i  in  1  clock; one clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- cfg_valid_i  in  1  descriptor valid.
- cfg_ready_o  out  1  descriptor accepted; high only in IDLE.
- cfg_base_i  in  ADDR_W  frame base byte address.
- cfg_stride_i  in  ADDR_W  byte distance between line starts.
- cfg_line_m1_i  in  ADDR_W  beats per line minus 1.
- cfg_lines_m1_i  in  LINES_W  lines per frame minus 1.
- new_line_o  out  1  one-cycle pulse to the offset former.
- line_size_o  out  ADDR_W  line size to the offset former; equals the latched cfg_line_m1.
- off_offset_i  in  ADDR_W  byte offset within the line, from the former.
- off_len_i  in  8  AXI burst length from the former.
- off_last_i  in  1  last burst of the line.
- off_valid_i  in  1  former output valid.
- off_ready_o  out  1  former output accepted.
- ar_addr_o  out  ADDR_W  AXI ARADDR.
- ar_len_o  out  8  AXI ARLEN.
- ar_valid_o  out  1  AXI ARVALID.
- ar_ready_i  in  1  AXI ARREADY.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when the last AR of the frame completes its handshake.

## Operation
States:
- IDLE
  - cfg_ready_o=1.
  - On cfg_valid_i: latch the descriptor, set line_base=cfg_base, row=0, go to LINE_START.
- LINE_START
  - new_line_o=1 and line_size_o=cfg_line_m1 for exactly one cycle, then go to SETTLE.
- SETTLE
  - One idle cycle so the former's pipeline reloads. off_ready_o=0. Then go to RUN.
- RUN
  - off_ready_o = !ar_valid_o.
  - On an off_valid_i & off_ready_o handshake, load the AR slot: addr = line_base + off_offset_i (mod 2^ADDR_W), len = off_len_i.
  - If off_last_i was set on that handshake, go to LINE_END; otherwise stay in RUN.
- LINE_END
  - off_ready_o=0. Wait for the AR handshake.
  - If row==cfg_lines_m1: pulse done_o and go to IDLE.
  - Else: line_base += stride (mod 2^ADDR_W), row++, go to LINE_START.

Rules:
- AR slot: single entry. ar_valid_o stays high with addr and len stable until ar_ready_i. It clears on the handshake unless reloaded in the same cycle; a reload is impossible because off_ready_o requires the slot to be empty.
- off_valid_i is ignored outside RUN.
- cfg_stride_i low log2(DATA_W/8) bits are treated as zero (masked on latch).
- A descriptor presented while busy is not accepted; cfg_valid_i must stay asserted until the handshake.

## Timing
- Reset values: cfg_ready_o=1 (IDLE), new_line_o=0, off_ready_o=0, ar_valid_o=0, ar_addr_o=0, ar_len_o=0, busy_o=0, done_o=0, line_size_o=0.
- Config handshake in cycle t: new_line_o pulses at t+1; RUN begins at t+3.
- Former handshake in cycle c: ar_valid_o is high at c+1. Each burst costs at least 2 cycles, because off_ready_o drops while the slot is full.
- Line turnaround: AR handshake of the last burst in cycle e gives new_line_o at e+1.
- done_o is asserted in the cycle after the final AR handshake; cfg_ready_o rises in the same cycle.
- Reset asserted mid-frame: all state returns to IDLE immediately. A pending AR is dropped; the AXI side must be reset with it.

## Configuration
- DMA_FRAME_SCHED_ABORT_EN
  - Defined: adds input abort_i (1 bit).
    - In LINE_START, SETTLE or RUN with the slot empty: go to IDLE next cycle.
    - Otherwise: finish the pending AR handshake, then go to IDLE.
    - done_o is not pulsed; adds output aborted_o, a one-cycle pulse on return to IDLE.
  - Undefined: no abort_i or aborted_o ports, and the frame always runs to completion.

## Structure
- Shared package dma_pkg holds:
  - addr_t (logic [ADDR_W-1:0]);
  - burst_len_t (logic [7:0]);
  - the state enum sched_state_e {IDLE, LINE_START, SETTLE, RUN, LINE_END}.
- One sub-module, dma_ar_slot: a single-entry valid/ready register for {addr, len} with async active-low reset.
- The offset former is instantiated beside this block, not inside it.

## Test plan
Unless a line says otherwise: DATA_W=64, former with MAX_BURST_LEN=255, ar_ready_i=1.
- Two-line frame: base=0x1000, stride=0x2000, line_m1=299, lines_m1=1 -> AR sequence (0x1000,255), (0x1800,43), (0x3000,255), (0x3800,43); one done_o pulse; exactly two new_line_o pulses.
- Single short line: base=0x0, line_m1=10, lines_m1=0 -> one AR (0x0,10), done_o the cycle after its handshake.
- Backpressure: ar_ready_i low for 5 cycles on each AR -> ar_addr_o and ar_len_o stable while valid, off_ready_o=0 throughout, same AR sequence as the two-line case.
- Address wrap: base=0xFFFF_F000, stride=0x1000, lines_m1=1, line_m1=3 -> ARs at 0xFFFF_F000, then 0x0000_0000.
- rst_ni asserted during RUN of line 3 -> all outputs at their reset values immediately; a new descriptor is accepted after release.
- DMA_FRAME_SCHED_ABORT_EN defined: abort_i pulsed while ar_valid_o=1 -> that AR completes, aborted_o pulses, no done_o, no further new_line_o.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types for the DMA read-path blocks.
//   addr_t        : byte address / stride / line length
//   burst_len_t   : AXI ARLEN
//   sched_state_e : frame scheduler states
package dma_pkg;

  localparam int unsigned DMA_ADDR_W  = 32;
  localparam int unsigned BURST_LEN_W = 8;

  typedef logic [DMA_ADDR_W-1:0]  addr_t;
  typedef logic [BURST_LEN_W-1:0] burst_len_t;

  typedef enum logic [2:0] {
    IDLE,
    LINE_START,
    SETTLE,
    RUN,
    LINE_END
  } sched_state_e;

endpackage

// File: rtl/dma_ar_slot.sv
// Single-entry valid/ready holding register for one AR command {addr, len}.
// Ports:
//   clk_i, rst_ni      : clock, async active-low reset
//   load_i             : capture addr_i/len_i and raise valid_o
//   addr_i, len_i      : command to capture
//   ready_i            : downstream ready; clears valid_o unless reloaded
//   valid_o, addr_o, len_o : held command, stable while valid_o && !ready_i
module dma_ar_slot
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  burst_len_t        len_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output burst_len_t        len_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  burst_len_t        len_q, len_d;

  // Load wins over the drain so a same-cycle reload would keep the slot full.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    len_d   = len_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      len_d   = len_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      addr_q  <= ADDR_W'(0);
      len_q   <= BURST_LEN_W'(0);
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign len_o   = len_q;

endmodule

// File: rtl/dma_frame_scheduler.sv
// Frame-level read-address sequencer. Accepts one frame descriptor, pulses the
// external offset former once per line and turns each (offset, len) it returns
// into an AXI AR command at line_base + offset.
// Ports:
//   clk_i, rst_ni                 : clock, async active-low reset
//   cfg_*                         : descriptor handshake (ready only in IDLE)
//   new_line_o, line_size_o       : line start pulse / beats-minus-1 to former
//   off_*                         : former output handshake
//   ar_addr_o/ar_len_o/ar_valid_o/ar_ready_i : AXI read-address channel
//   busy_o, done_o                : not-idle flag, end-of-frame pulse
// Optional: define DMA_FRAME_SCHED_ABORT_EN to add abort_i / aborted_o.
module dma_frame_scheduler
  import dma_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LINES_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
`ifdef DMA_FRAME_SCHED_ABORT_EN
  input  logic               abort_i,
  output logic               aborted_o,
`endif
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [ADDR_W-1:0]  cfg_base_i,
  input  logic [ADDR_W-1:0]  cfg_stride_i,
  input  logic [ADDR_W-1:0]  cfg_line_m1_i,
  input  logic [LINES_W-1:0] cfg_lines_m1_i,
  output logic               new_line_o,
  output logic [ADDR_W-1:0]  line_size_o,
  input  logic [ADDR_W-1:0]  off_offset_i,
  input  burst_len_t         off_len_i,
  input  logic               off_last_i,
  input  logic               off_valid_i,
  output logic               off_ready_o,
  output logic [ADDR_W-1:0]  ar_addr_o,
  output burst_len_t         ar_len_o,
  output logic               ar_valid_o,
  input  logic               ar_ready_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned BYTES_PER_BEAT = DATA_W / 8;
  // Strides are whole-beat multiples: sub-beat bits are dropped on latch.
  localparam logic [ADDR_W-1:0] STRIDE_MASK = ~(ADDR_W'(BYTES_PER_BEAT - 1));

  sched_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  line_base_q, line_base_d;
  logic [ADDR_W-1:0]  stride_q, stride_d;
  logic [ADDR_W-1:0]  line_m1_q, line_m1_d;
  logic [LINES_W-1:0] lines_m1_q, lines_m1_d;
  logic [LINES_W-1:0] row_q, row_d;
  logic               done_q, done_d;
  logic               cfg_ready_q, busy_q, new_line_q, off_ready_q;

  logic               slot_load_c;
  logic               slot_valid_nxt_c;
  logic               ar_hs_c;
  logic               off_hs_c;
  logic               abort_c;

  assign ar_hs_c  = ar_valid_o & ar_ready_i;
  assign off_hs_c = off_valid_i & off_ready_o;

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    line_base_d = line_base_q;
    stride_d    = stride_q;
    line_m1_d   = line_m1_q;
    lines_m1_d  = lines_m1_q;
    row_d       = row_q;
    done_d      = 1'b0;
    slot_load_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          line_base_d = cfg_base_i;
          stride_d    = cfg_stride_i & STRIDE_MASK;
          line_m1_d   = cfg_line_m1_i;
          lines_m1_d  = cfg_lines_m1_i;
          row_d       = LINES_W'(0);
          state_d     = LINE_START;
        end
      end
      LINE_START: state_d = abort_c ? IDLE : SETTLE;
      SETTLE:     state_d = abort_c ? IDLE : RUN;
      RUN: begin
        if (abort_c) begin
          // An in-flight AR must finish its handshake before we drop out.
          if (!ar_valid_o || ar_hs_c) begin
            state_d = IDLE;
          end
        end else if (off_hs_c) begin
          slot_load_c = 1'b1;
          if (off_last_i) begin
            state_d = LINE_END;
          end
        end
      end
      LINE_END: begin
        if (ar_hs_c) begin
          if (abort_c) begin
            state_d = IDLE;
          end else if (row_q == lines_m1_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            line_base_d = line_base_q + stride_q;
            row_d       = row_q + LINES_W'(1);
            state_d     = LINE_START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Former may only hand over a burst when the slot will be empty next cycle.
  assign slot_valid_nxt_c = slot_load_c | (ar_valid_o & ~ar_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      line_base_q <= ADDR_W'(0);
      stride_q    <= ADDR_W'(0);
      line_m1_q   <= ADDR_W'(0);
      lines_m1_q  <= LINES_W'(0);
      row_q       <= LINES_W'(0);
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      new_line_q  <= 1'b0;
      off_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_base_q <= line_base_d;
      stride_q    <= stride_d;
      line_m1_q   <= line_m1_d;
      lines_m1_q  <= lines_m1_d;
      row_q       <= row_d;
      done_q      <= done_d;
      cfg_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      new_line_q  <= (state_d == LINE_START);
      off_ready_q <= (state_d == RUN) & ~slot_valid_nxt_c;
    end
  end

`ifdef DMA_FRAME_SCHED_ABORT_EN
  logic abort_pend_q, abort_pend_d;
  logic aborted_q, aborted_d;

  // Abort is sticky until the frame actually leaves for IDLE.
  assign abort_c = abort_i | abort_pend_q;

  always_comb begin
    abort_pend_d = (state_q != IDLE) && (state_d != IDLE) && abort_c;
    aborted_d    = (state_q != IDLE) && (state_d == IDLE) && abort_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
    end
  end

  assign aborted_o = aborted_q;
`else
  assign abort_c = 1'b0;
`endif

  dma_ar_slot #(
    .ADDR_W (ADDR_W)
  ) u_ar_slot (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (slot_load_c),
    .addr_i  (line_base_q + off_offset_i),
    .len_i   (off_len_i),
    .ready_i (ar_ready_i),
    .valid_o (ar_valid_o),
    .addr_o  (ar_addr_o),
    .len_o   (ar_len_o)
  );

  assign cfg_ready_o = cfg_ready_q;
  assign busy_o      = busy_q;
  assign new_line_o  = new_line_q;
  assign off_ready_o = off_ready_q;
  assign done_o      = done_q;
  assign line_size_o = line_m1_q;

endmodule

// File: tb/tb_dma_frame_scheduler.sv
// Scoreboard bench for dma_frame_scheduler: a behavioural offset former
// (8-byte beats, max 256 beats per burst) feeds the DUT, directed frames push
// their expected AR sequence, and a monitor pops and compares on each AR
// handshake. Define DMA_FRAME_SCHED_ABORT_EN to include the abort scenario.
module tb_dma_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_base = '0, cfg_stride = '0, cfg_line_m1 = '0;
  logic [15:0] cfg_lines_m1 = '0;
  logic        new_line;
  logic [31:0] line_size;
  logic [31:0] off_offset;
  logic [7:0]  off_len;
  logic        off_last, off_valid;
  logic        off_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        ar_valid;
  logic        ar_ready;
  logic        busy, done;
`ifdef DMA_FRAME_SCHED_ABORT_EN
  logic        abort = 1'b0;
  logic        aborted;
  int          ab_cnt = 0;
`endif

  always #5 clk = ~clk;

  dma_frame_scheduler dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
`ifdef DMA_FRAME_SCHED_ABORT_EN
    .abort_i        (abort),
    .aborted_o      (aborted),
`endif
    .cfg_valid_i    (cfg_valid),
    .cfg_ready_o    (cfg_ready),
    .cfg_base_i     (cfg_base),
    .cfg_stride_i   (cfg_stride),
    .cfg_line_m1_i  (cfg_line_m1),
    .cfg_lines_m1_i (cfg_lines_m1),
    .new_line_o     (new_line),
    .line_size_o    (line_size),
    .off_offset_i   (off_offset),
    .off_len_i      (off_len),
    .off_last_i     (off_last),
    .off_valid_i    (off_valid),
    .off_ready_o    (off_ready),
    .ar_addr_o      (ar_addr),
    .ar_len_o       (ar_len),
    .ar_valid_o     (ar_valid),
    .ar_ready_i     (ar_ready),
    .busy_o         (busy),
    .done_o         (done)
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   nl_cnt = 0;
  int   done_cnt = 0;
  bit   bp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [7:0] l);
    exp_t e;
    e.addr = a;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  // Offset former model: splits each line into bursts of up to 256 beats.
  initial begin
    longint      f_rem;
    logic [31:0] f_off;
    logic [31:0] p_size;
    bit          f_active, p_hs, p_nl;
    longint      burst;
    f_rem = 0; f_off = '0; p_size = '0;
    f_active = 0; p_hs = 0; p_nl = 0;
    off_valid = 0; off_offset = '0; off_len = '0; off_last = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        f_active = 0; p_hs = 0; p_nl = 0;
        off_valid = 0; off_last = 0;
        continue;
      end
      burst = (f_rem > 256) ? 256 : f_rem;
      if (p_hs) begin
        f_rem = f_rem - burst;
        f_off = f_off + 32'(burst * 8);
        if (f_rem == 0) f_active = 0;
      end
      if (p_nl) begin
        f_active = 1;
        f_rem    = longint'(p_size) + 1;
        f_off    = '0;
      end
      burst      = (f_rem > 256) ? 256 : f_rem;
      off_valid  = f_active;
      off_offset = f_off;
      off_len    = 8'(burst - 1);
      off_last   = (f_rem == burst);
      p_hs   = off_valid && off_ready;
      p_nl   = new_line;
      p_size = line_size;
    end
  end

  // AXI ready driver: in backpressure mode hold ready low 5 cycles per AR.
  initial begin
    int bp_cnt;
    bp_cnt = 0;
    ar_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_en && ar_valid && rst_n) begin
        if (bp_cnt < 5) begin
          ar_ready = 1'b0;
          bp_cnt++;
        end else begin
          ar_ready = 1'b1;
          bp_cnt = 0;
        end
      end else begin
        ar_ready = 1'b1;
        bp_cnt = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on each AR handshake, checks hold/done timing.
  initial begin
    int          cyc, last_hs_cyc;
    bit          hold_v;
    logic [31:0] hold_addr;
    logic [7:0]  hold_len;
    exp_t        e;
    cyc = 0; last_hs_cyc = -10; hold_v = 0; hold_addr = '0; hold_len = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        hold_v = 0;
        continue;
      end
      if (new_line) nl_cnt++;
`ifdef DMA_FRAME_SCHED_ABORT_EN
      if (aborted) ab_cnt++;
`endif
      if (done) begin
        done_cnt++;
        chk("done_after_last_ar", 64'(cyc), 64'(last_hs_cyc + 1));
        chk("cfg_ready_with_done", 64'(cfg_ready), 64'd1);
      end
      if (ar_valid) begin
        chk("off_ready_while_slot_full", 64'(off_ready), 64'd0);
        if (hold_v) begin
          chk("ar_addr_stable", 64'(ar_addr), 64'(hold_addr));
          chk("ar_len_stable", 64'(ar_len), 64'(hold_len));
        end
        if (ar_ready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ar: got addr 0x%0h len %0d with empty scoreboard", ar_addr, ar_len);
          end else begin
            e = exp_q.pop_front();
            chk("ar_addr", 64'(ar_addr), 64'(e.addr));
            chk("ar_len", 64'(ar_len), 64'(e.len));
          end
          last_hs_cyc = cyc;
          hold_v = 0;
        end else begin
          hold_v = 1;
          hold_addr = ar_addr;
          hold_len = ar_len;
        end
      end else begin
        hold_v = 0;
      end
    end
  end

  task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                             input logic [31:0] lm1, input logic [15:0] lines_m1);
    int n;
    @(negedge clk);
    nl_cnt = 0;
    done_cnt = 0;
    cfg_base = base; cfg_stride = stride; cfg_line_m1 = lm1; cfg_lines_m1 = lines_m1;
    cfg_valid = 1'b1;
    n = 0;
    while (!cfg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cfg_accept_timeout", 64'(n >= 100), 64'd0);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("new_line_after_cfg", 64'(new_line), 64'd1);
    chk("cfg_ready_busy", 64'(cfg_ready), 64'd0);
    chk("busy_after_cfg", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input int exp_nl);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_timeout", 64'(n >= 5000), 64'd0);
    repeat (3) @(negedge clk);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("new_line_pulses", 64'(nl_cnt), 64'(exp_nl));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("idle_after_frame", 64'(cfg_ready), 64'd1);
  endtask

  task automatic chk_reset_values();
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_new_line", 64'(new_line), 64'd0);
    chk("rst_off_ready", 64'(off_ready), 64'd0);
    chk("rst_ar_valid", 64'(ar_valid), 64'd0);
    chk("rst_ar_addr", 64'(ar_addr), 64'd0);
    chk("rst_ar_len", 64'(ar_len), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_line_size", 64'(line_size), 64'd0);
  endtask

  initial begin
    #12;
    chk_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Two-line frame, two bursts per line.
    push_exp(32'h0000_1000, 8'd255);
    push_exp(32'h0000_1800, 8'd43);
    push_exp(32'h0000_3000, 8'd255);
    push_exp(32'h0000_3800, 8'd43);
    start_frame(32'h0000_1000, 32'h0000_2000, 32'd299, 16'd1);
    wait_done(2);
    chk("line_size_latched", 64'(line_size), 64'd299);

    // Single short line.
    push_exp(32'h0000_0000, 8'd10);
    start_frame(32'h0000_0000, 32'h0000_0100, 32'd10, 16'd0);
    wait_done(1);

    // Backpressure on every AR.
    bp_en = 1'b1;
    push_exp(32'h0000_1000, 8'd255);
    push_exp(32'h0000_1800, 8'd43);
    push_exp(32'h0000_3000, 8'd255);
    push_exp(32'h0000_3800, 8'd43);
    start_frame(32'h0000_1000, 32'h0000_2000, 32'd299, 16'd1);
    wait_done(2);
    bp_en = 1'b0;

    // Address wrap across 2^32.
    push_exp(32'hFFFF_F000, 8'd3);
    push_exp(32'h0000_0000, 8'd3);
    start_frame(32'hFFFF_F000, 32'h0000_1000, 32'd3, 16'd1);
    wait_done(2);

    // Sub-beat stride bits are ignored.
    push_exp(32'h0000_0100, 8'd0);
    push_exp(32'h0000_1100, 8'd0);
    start_frame(32'h0000_0100, 32'h0000_1007, 32'd0, 16'd1);
    wait_done(2);

    // Reset during RUN of the third line.
    begin
      int n;
      push_exp(32'h0000_4000, 8'd10);
      push_exp(32'h0000_4100, 8'd10);
      start_frame(32'h0000_4000, 32'h0000_0100, 32'd10, 16'd3);
      n = 0;
      while (nl_cnt < 3 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("third_line_timeout", 64'(n >= 2000), 64'd0);
      n = 0;
      while (!off_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("third_line_run_timeout", 64'(n >= 50), 64'd0);
      chk("busy_before_reset", 64'(busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values();
      chk("scoreboard_at_reset", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end

    // New descriptor accepted after reset release.
    push_exp(32'h0000_2000, 8'd10);
    start_frame(32'h0000_2000, 32'h0000_0100, 32'd10, 16'd0);
    wait_done(1);

`ifdef DMA_FRAME_SCHED_ABORT_EN
    // Abort while an AR is held: it completes, then aborted_o, no done_o.
    begin
      int n;
      bp_en = 1'b1;
      ab_cnt = 0;
      push_exp(32'h0000_8000, 8'd255);
      start_frame(32'h0000_8000, 32'h0000_1000, 32'd299, 16'd3);
      n = 0;
      while (!ar_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("abort_ar_timeout", 64'(n >= 100), 64'd0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n = 0;
      while (ab_cnt == 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("aborted_timeout", 64'(n >= 200), 64'd0);
      repeat (10) @(negedge clk);
      chk("aborted_pulses", 64'(ab_cnt), 64'd1);
      chk("abort_no_done", 64'(done_cnt), 64'd0);
      chk("abort_new_lines", 64'(nl_cnt), 64'd1);
      chk("abort_scoreboard_empty", 64'(exp_q.size()), 64'd0);
      chk("abort_idle", 64'(cfg_ready), 64'd1);
      bp_en = 1'b0;
    end
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
